// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: default primitive tap masks per width and the default seed.
package lfsr_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    // Galois tap masks (bit k = feedback into bit k, bit 0 implied) for primitive polynomials.
    function automatic logic [31:0] default_taps(input int w);
        logic [31:0] taps;
        case (w)
            3:       taps = 32'h0000_0002;
            4:       taps = 32'h0000_0002;
            5:       taps = 32'h0000_0004;
            6:       taps = 32'h0000_0002;
            7:       taps = 32'h0000_0002;
            8:       taps = 32'h0000_001C;
            9:       taps = 32'h0000_0010;
            10:      taps = 32'h0000_0008;
            11:      taps = 32'h0000_0004;
            12:      taps = 32'h0000_0052;
            13:      taps = 32'h0000_001A;
            14:      taps = 32'h0000_0442;
            15:      taps = 32'h0000_0002;
            16:      taps = 32'h0000_100A;
            default: taps = 32'h0000_0002;
        endcase
        return taps;
    endfunction

    function automatic logic [63:0] default_seed(input int w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle between an LFSR generator and its user.
interface lfsr_gen_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] step_cnt;
    logic             period_done;
    logic             lockup;

    modport master (
        output en, load, load_val,
        input  q, step_cnt, period_done, lockup
    );

    modport slave (
        input  en, load, load_val,
        output q, step_cnt, period_done, lockup
    );
endinterface

// File: rtl/lfsr_step.sv
// One Galois LFSR step, purely combinational.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_next
);

    logic w_fb;

    // Shift towards the MSB; the MSB wraps to bit 0 and is XORed into tapped bits.
    always_comb begin
        w_fb      = i_q[WIDTH-1];
        o_next    = '0;
        o_next[0] = w_fb;
        for (int k = 1; k < WIDTH; k++) begin
            o_next[k] = i_q[k-1] ^ (TAPS[k] & w_fb);
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with step enable, seed load, zero-load lockup recovery and period tracking.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(default_seed(WIDTH))
) (
    input  logic       clk,
    input  logic       rst,
    lfsr_gen_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_cnt;
    logic             r_pd;
    logic             r_lk;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_start_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_pd_nxt;
    logic             w_lk_nxt;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .i_q    (r_q),
        .o_next (w_step)
    );

    // Priority mux: load beats en beats hold; a zero load is replaced by SEED so q never reaches 0.
    always_comb begin
        w_q_nxt     = r_q;
        w_start_nxt = r_start;
        w_cnt_nxt   = r_cnt;
        w_pd_nxt    = 1'b0;
        w_lk_nxt    = 1'b0;
        if (bus.load) begin
            w_cnt_nxt = '0;
            if (bus.load_val != '0) begin
                w_q_nxt     = bus.load_val;
                w_start_nxt = bus.load_val;
            end else begin
                w_q_nxt     = SEED;
                w_start_nxt = SEED;
                w_lk_nxt    = 1'b1;
            end
        end else if (bus.en) begin
            w_q_nxt = w_step;
            if (w_step == r_start) begin
                w_cnt_nxt = '0;
                w_pd_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else begin
            w_q_nxt = r_q;
        end
    end

    // State registers with synchronous reset to SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= SEED;
            r_start <= SEED;
            r_cnt   <= '0;
            r_pd    <= 1'b0;
            r_lk    <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_start <= w_start_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pd    <= w_pd_nxt;
            r_lk    <= w_lk_nxt;
        end
    end

    assign bus.q           = r_q;
    assign bus.step_cnt    = r_cnt;
    assign bus.period_done = r_pd;
    assign bus.lockup      = r_lk;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed-vector bench for lfsr_gen: 5-bit instance via table and sequences, 8-bit instance via scoreboard.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst5;
    logic rst8;

    lfsr_gen_if #(.WIDTH(5)) b5();
    lfsr_gen_if #(.WIDTH(8)) b8();

    lfsr_gen #(.WIDTH(5), .TAPS(5'b00100), .SEED(5'h1F)) u5 (
        .clk (clk),
        .rst (rst5),
        .bus (b5.slave)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'(lfsr_pkg::default_taps(8))), .SEED(8'hFF)) u8 (
        .clk (clk),
        .rst (rst8),
        .bus (b8.slave)
    );

    typedef struct packed {
        logic       rst;
        logic       load;
        logic       en;
        logic [4:0] lv;
        logic [4:0] eq;
        logic [4:0] ec;
        logic       epd;
        logic       elk;
    } vec_t;

    vec_t tbl [16];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] mstep(input logic [31:0] s, input int w, input logic [31:0] taps);
        logic [31:0] m;
        logic [31:0] r;
        m = 32'((64'd1 << w) - 64'd1);
        r = (s << 1) & m;
        if (s[w-1]) r = r ^ (taps | 32'd1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk5(input string tag, input logic [4:0] eq, input logic [4:0] ec,
                        input logic epd, input logic elk);
        chk({tag, ".q"},           32'(b5.q),           32'(eq));
        chk({tag, ".step_cnt"},    32'(b5.step_cnt),    32'(ec));
        chk({tag, ".period_done"}, 32'(b5.period_done), 32'(epd));
        chk({tag, ".lockup"},      32'(b5.lockup),      32'(elk));
    endtask

    task automatic drive5(input logic r, input logic ld, input logic e, input logic [4:0] v);
        rst5        = r;
        b5.load     = ld;
        b5.en       = e;
        b5.load_val = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mc;
        logic        e;
        int          pd_cnt;
        int          seen_cnt;
        logic        seen [256];

        rst8        = 1'b1;
        b8.en       = 1'b0;
        b8.load     = 1'b0;
        b8.load_val = 8'h00;
        drive5(1'b1, 1'b0, 1'b0, 5'h00);

        //             rst   load  en    lv     q      cnt    pd    lk
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'h00, 5'h1F, 5'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h1B, 5'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h13, 5'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'h00, 5'h13, 5'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 5'h05, 5'h05, 5'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h0A, 5'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h14, 5'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h0D, 5'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'h00, 5'h1F, 5'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'h00, 5'h1F, 5'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h1B, 5'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 5'h00, 5'h1F, 5'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 5'h03, 5'h03, 5'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 5'h07, 5'h07, 5'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 5'h10, 5'h10, 5'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h05, 5'd1, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            drive5(tbl[i].rst, tbl[i].load, tbl[i].en, tbl[i].lv);
            tick();
            chk5($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ec, tbl[i].epd, tbl[i].elk);
        end

        // Full period from reset: pulse after step 31, count 30 just before.
        drive5(1'b1, 1'b0, 1'b0, 5'h00);
        tick();
        drive5(1'b0, 1'b0, 1'b1, 5'h00);
        mq = 32'h1F;
        for (int i = 1; i <= 31; i++) begin
            tick();
            mq = mstep(mq, 5, 32'h04);
            chk5($sformatf("run%0d", i), mq[4:0], (i == 31) ? 5'd0 : 5'(i), (i == 31), 1'b0);
        end
        chk("run_end_q", 32'(b5.q), 32'h1F);

        // Load with en high: no step, new period start at 01.
        drive5(1'b0, 1'b1, 1'b1, 5'h01);
        tick();
        chk5("load01", 5'h01, 5'd0, 1'b0, 1'b0);
        drive5(1'b0, 1'b0, 1'b1, 5'h00);
        mq = 32'h01;
        for (int i = 1; i <= 31; i++) begin
            tick();
            mq = mstep(mq, 5, 32'h04);
            chk5($sformatf("l01_%0d", i), mq[4:0], (i == 31) ? 5'd0 : 5'(i), (i == 31), 1'b0);
        end
        chk("l01_end_q", 32'(b5.q), 32'h01);

        // Zero load triggers lockup recovery for exactly one cycle.
        drive5(1'b0, 1'b1, 1'b0, 5'h00);
        tick();
        chk5("zload", 5'h1F, 5'd0, 1'b0, 1'b1);
        drive5(1'b0, 1'b0, 1'b0, 5'h00);
        tick();
        chk5("zload_after", 5'h1F, 5'd0, 1'b0, 1'b0);

        // Alternating en for 62 cycles: 31 steps, one pulse, stable on idle cycles.
        mq = 32'h1F;
        mc = 32'd0;
        pd_cnt = 0;
        for (int i = 0; i < 62; i++) begin
            e = (i % 2 == 0);
            drive5(1'b0, 1'b0, e, 5'h00);
            tick();
            if (e) begin
                mq = mstep(mq, 5, 32'h04);
                mc = (mq == 32'h1F) ? 32'd0 : mc + 32'd1;
            end
            chk5($sformatf("tog%0d", i), mq[4:0], mc[4:0], e && (mq == 32'h1F), 1'b0);
            if (b5.period_done) pd_cnt++;
        end
        chk("tog_pd_count", 32'(pd_cnt), 32'd1);

        // Reset mid-sequence overrides load/en and clears everything.
        drive5(1'b0, 1'b0, 1'b1, 5'h00);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_cnt", 32'(b5.step_cnt), 32'd10);
        drive5(1'b1, 1'b1, 1'b1, 5'h00);
        tick();
        chk5("mid_rst", 5'h1F, 5'd0, 1'b0, 1'b0);
        drive5(1'b0, 1'b0, 1'b0, 5'h00);

        // 8-bit free-running: pulse every 255 steps, all non-zero states once per period.
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen_cnt = 0;
        tick();
        rst8  = 1'b0;
        b8.en = 1'b1;
        mq = 32'hFF;
        for (int i = 1; i <= 765; i++) begin
            tick();
            mq = mstep(mq, 8, 32'h1C);
            chk($sformatf("w8_q%0d", i), 32'(b8.q), mq);
            chk($sformatf("w8_pd%0d", i), 32'(b8.period_done), 32'((i % 255) == 0));
            if (i <= 255) begin
                chk($sformatf("w8_dup%0d", i), 32'(seen[b8.q]), 32'd0);
                if (!seen[b8.q] && b8.q != 8'h00) seen_cnt++;
                seen[b8.q] = 1'b1;
            end
        end
        chk("w8_visited", 32'(seen_cnt), 32'd255);
        chk("w8_zero_seen", 32'(seen[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
